// File: rtl/crc_check.sv
// CRC-5 (x^5+x^2+1) codeword checker: captures a 15-bit {payload, crc} word and checks it serially, MSB first.
// Optional saturating error counter is enabled by defining CRC_CHECK_ERRCNT_EN.
module crc_check (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [14:0] data_in,
    output logic        busy,
    output logic        done,
    output logic        crc_ok,
    output logic [9:0]  data_out,
    output logic [7:0]  err_cnt
);

    // Handshake: en is a one-cycle valid with no ready; it is accepted in IDLE or DONE
    // and ignored in SHIFT, so the source must not present a word while busy is high.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [14:0] code_q;
    logic [15:0] code_ext;
    logic [4:0]  lfsr_q, lfsr_nxt;
    logic [3:0]  cnt_q;
    logic        bit_cur, fb, start, last;

    assign start    = en && (state != SHIFT);
    assign last     = (state == SHIFT) && (cnt_q == 4'd0);
    // The counter walks the captured word from bit 14 down to bit 0; the payload stays intact.
    assign code_ext = {1'b0, code_q};
    assign bit_cur  = code_ext[cnt_q];
    assign fb       = lfsr_q[4] ^ bit_cur;
    assign lfsr_nxt = {lfsr_q[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt_q == 4'd0) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = en ? SHIFT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q   <= 15'd0;
            lfsr_q   <= 5'd0;
            cnt_q    <= 4'd0;
            crc_ok   <= 1'b0;
            data_out <= 10'd0;
        end else if (start) begin
            code_q <= data_in;
            lfsr_q <= 5'd0;
            cnt_q  <= 4'd14;
        end else if (state == SHIFT) begin
            lfsr_q <= lfsr_nxt;
            cnt_q  <= cnt_q - 4'd1;
            if (cnt_q == 4'd0) begin
                crc_ok   <= (lfsr_nxt == 5'd0);
                data_out <= code_q[14:5];
            end
        end
    end

`ifdef CRC_CHECK_ERRCNT_EN
    logic [7:0] err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 8'd0;
        end else if (last && (lfsr_nxt != 5'd0) && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule
